// File: rtl/psum_adder_sched.sv
// Partial-sum adder scheduler: takes one psum from each PE queue in fixed order
// (PE0, PE1, PE2), saturates the sum and emits NUM_OUT output packets per pass.
module psum_adder_sched #(
   parameter int         DWIDTH   = 8,
   parameter int         PWIDTH   = 47,
   parameter int         NUM_OUT  = 9,
   parameter logic [2:0] SRC_ADDR = 3'd4,
   parameter logic [2:0] DST_ADDR = 3'd5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [DWIDTH-1:0] in0_data,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DWIDTH-1:0] in1_data,
   input  logic              in2_valid,
   output logic              in2_ready,
   input  logic [DWIDTH-1:0] in2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] out_packet,
   output logic              busy,
   output logic              done,
   output logic              ovf
);

   localparam int              AW       = DWIDTH + 2;
   localparam logic [AW-1:0]   MAX_VAL  = {2'b00, {DWIDTH{1'b1}}};
   localparam logic [7:0]      LAST_IDX = 8'(NUM_OUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_ACC2, S_SEND} state_t;

   state_t            r_state;
   logic [AW-1:0]     r_acc;
   logic [7:0]        r_idx;
   logic [PWIDTH-1:0] r_packet;
   logic              r_done;
   logic              r_ovf;

   logic [AW-1:0]     w_sum;
   logic              w_sat;
   logic [DWIDTH-1:0] w_data;
   logic [PWIDTH-1:0] w_packet;

   // The packet is built from the final sum so it can be registered on the
   // in2 handshake and held unchanged for the whole SEND state.
   assign w_sum  = r_acc + AW'(in2_data);
   assign w_sat  = (w_sum > MAX_VAL);
   assign w_data = w_sat ? {DWIDTH{1'b1}} : w_sum[DWIDTH-1:0];

   always_comb begin
      w_packet             = '0;
      w_packet[45:43]      = DST_ADDR;
      w_packet[42:40]      = SRC_ADDR;
      w_packet[39:32]      = r_idx;
      w_packet[DWIDTH-1:0] = w_data;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_idx    <= '0;
         r_packet <= '0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               // The done cycle is already IDLE; a start landing on it is dropped.
               if (start && !r_done) begin
                  r_acc   <= '0;
                  r_idx   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= S_ACC0;
               end
            end
            S_ACC0: begin
               if (in0_valid) begin
                  r_acc   <= AW'(in0_data);
                  r_state <= S_ACC1;
               end
            end
            S_ACC1: begin
               if (in1_valid) begin
                  r_acc   <= r_acc + AW'(in1_data);
                  r_state <= S_ACC2;
               end
            end
            S_ACC2: begin
               if (in2_valid) begin
                  r_acc    <= w_sum;
                  r_packet <= w_packet;
                  if (w_sat) r_ovf <= 1'b1;
                  r_state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (r_idx == LAST_IDX) begin
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx   <= r_idx + 8'd1;
                     r_acc   <= '0;
                     r_state <= S_ACC0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in0_ready  = (r_state == S_ACC0);
   assign in1_ready  = (r_state == S_ACC1);
   assign in2_ready  = (r_state == S_ACC2);
   assign out_valid  = (r_state == S_SEND);
   assign busy       = (r_state != S_IDLE);
   assign out_packet = r_packet;
   assign done       = r_done;
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_psum_adder_sched.sv
// Self-checking bench for psum_adder_sched: queue-based PE drivers, an expected
// packet model, and one compare process sampling on the falling edge.
module tb_psum_adder_sched;

   localparam int NUM_OUT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in0_valid, in1_valid, in2_valid;
   logic        in0_ready, in1_ready, in2_ready;
   logic [7:0]  in0_data, in1_data, in2_data;
   logic        out_valid, out_ready;
   logic [46:0] out_packet;
   logic        busy, done, ovf;

   psum_adder_sched #(
      .DWIDTH(8), .PWIDTH(47), .NUM_OUT(NUM_OUT), .SRC_ADDR(3'd4), .DST_ADDR(3'd5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
      .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
      .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [7:0] idx;
      logic       sat;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] q0[$], q1[$], q2[$];
   int         hs_log[$];
   logic [7:0] got_data[$], got_idx[$];
   logic       en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
   int         n_cmp = 0, n_fail = 0;
   int         cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, pass_n = 0;
   logic       model_ovf = 1'b0, expect_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [46:0] pkt(input logic [7:0] idx, input logic [7:0] data);
      return (47'(5) << 43) | (47'(4) << 40) | (47'(idx) << 32) | 47'(data);
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic new_pass();
      pass_n = 0;
      got_data.delete();
      got_idx.delete();
   endtask

   task automatic push(input int a, input int b, input int c);
      exp_t e;
      int   s;
      q0.push_back(8'(a));
      q1.push_back(8'(b));
      q2.push_back(8'(c));
      s      = a + b + c;
      e.sat  = (s > 255);
      e.data = e.sat ? 8'd255 : 8'(s);
      e.idx  = 8'(pass_n);
      pass_n++;
      exp_q.push_back(e);
   endtask

   task automatic do_start();
      start     = 1'b1;
      start_cyc = cyc + 1;
      tick(1);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c0 = done_cnt;
      int k  = 0;
      while (done_cnt == c0 && k < budget) begin
         tick(1);
         k++;
      end
      if (done_cnt == c0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_done: pass not complete within %0d cycles", budget);
      end
   endtask

   // PE queue drivers: valid follows the queue, pop on a sampled handshake.
   initial begin
      logic       h0, h1, h2;
      logic [7:0] dummy;
      in0_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
      in0_data  = '0;   in1_data  = '0;   in2_data  = '0;
      forever begin
         @(negedge clk);
         h0 = in0_valid & in0_ready;
         h1 = in1_valid & in1_ready;
         h2 = in2_valid & in2_ready;
         @(posedge clk);
         #1;
         if (h0 && q0.size() > 0) begin dummy = q0.pop_front(); hs_log.push_back(0); end
         if (h1 && q1.size() > 0) begin dummy = q1.pop_front(); hs_log.push_back(1); end
         if (h2 && q2.size() > 0) begin dummy = q2.pop_front(); hs_log.push_back(2); end
         in0_valid = en0 && (q0.size() > 0);
         in1_valid = en1 && (q1.size() > 0);
         in2_valid = en2 && (q2.size() > 0);
         in0_data  = (q0.size() > 0) ? q0[0] : 8'd0;
         in1_data  = (q1.size() > 0) ? q1[0] : 8'd0;
         in2_data  = (q2.size() > 0) ? q2[0] : 8'd0;
      end
   end

   // Compare process: done, ovf and packet contents against the model.
   initial begin
      exp_t e;
      logic exp_ovf;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_ovf   = 1'b0;
            expect_done = 1'b0;
         end else begin
            if (expect_done) begin
               check("done_pulse", done, 1);
               check("busy_at_done", busy, 0);
               done_cyc    = cyc;
               done_cnt++;
               expect_done = 1'b0;
            end else begin
               check("no_done", done, 0);
            end
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_packet: got %0h, expected no packet", out_packet);
               end else begin
                  e       = exp_q[0];
                  exp_ovf = ((e.idx == 0) ? 1'b0 : model_ovf) | e.sat;
                  check("ovf", ovf, exp_ovf);
                  check("busy_in_send", busy, 1);
                  if (out_ready) begin
                     check("packet", out_packet, pkt(e.idx, e.data));
                     got_data.push_back(out_packet[7:0]);
                     got_idx.push_back(out_packet[39:32]);
                     model_ovf = exp_ovf;
                     e = exp_q.pop_front();
                     if (e.idx == 8'(NUM_OUT - 1)) expect_done = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [46:0] snap;
      int          k;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      tick(2);
      check("rst_readys", {in0_ready, in1_ready, in2_ready}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_packet", out_packet, 0);
      check("rst_busy_done_ovf", {busy, done, ovf}, 0);
      rst_n = 1'b1;
      tick(2);

      // Basic pass, with a stray start mid-pass that must be ignored.
      en0 = 1; en1 = 1; en2 = 1; out_ready = 1;
      new_pass();
      push(10, 20, 30); push(1, 2, 3); push(0, 0, 0);
      do_start();
      check("start_busy", busy, 1);
      check("start_in0_ready", in0_ready, 1);
      tick(5);
      start = 1'b1; tick(1); start = 1'b0;
      wait_done(40);
      check("done_latency", done_cyc - start_cyc, 12);
      check("p1_count", got_data.size(), 3);
      check("p1_data0", got_data[0], 60);
      check("p1_data1", got_data[1], 6);
      check("p1_data2", got_data[2], 0);
      check("p1_idx2", got_idx[2], 2);
      check("p1_ovf", ovf, 0);
      tick(3);
      check("p1_idle", busy, 0);

      // Saturation; ovf is sticky to the end of the pass and clears on start.
      new_pass();
      push(200, 100, 50); push(1, 1, 1); push(0, 0, 0);
      do_start();
      wait_done(40);
      check("sat_data", got_data[0], 255);
      check("sat_data1", got_data[1], 3);
      tick(2);
      check("ovf_sticky", ovf, 1);

      // Out-of-order arrival and start with nothing pending.
      en0 = 0; en1 = 0; en2 = 0;
      new_pass();
      push(7, 8, 9); push(2, 2, 2); push(3, 3, 3);
      do_start();
      check("ovf_cleared", ovf, 0);
      hs_log.delete();
      tick(3);
      check("hold_acc0", {busy, in0_ready, in1_ready, in2_ready}, 4'b1100);
      en2 = 1;
      tick(3);
      check("in2_stalled", {in0_ready, in2_ready}, 2'b10);
      en1 = 1;
      tick(2);
      check("in1_stalled", {in0_ready, in1_ready}, 2'b10);
      en0 = 1;
      wait_done(40);
      check("ooo_order", {hs_log[0][1:0], hs_log[1][1:0], hs_log[2][1:0]}, 6'b00_01_10);
      check("ooo_sum", got_data[0], 24);

      // Backpressure on the output.
      out_ready = 0;
      new_pass();
      push(5, 6, 7); push(9, 9, 9); push(1, 0, 0);
      do_start();
      k = 0;
      while (!out_valid && k < 20) begin tick(1); k++; end
      check("bp_valid", out_valid, 1);
      snap = out_packet;
      check("bp_literal", snap, 47'h2C0000000012);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_packet", out_packet, snap);
         check("bp_readys", {in0_ready, in1_ready, in2_ready}, 0);
      end
      out_ready = 1;
      wait_done(40);
      check("bp_count", got_data.size(), 3);
      check("bp_data1", got_data[1], 27);

      // Asynchronous reset while in ACC1 of the second output.
      new_pass();
      push(250, 10, 0); push(4, 5, 6); push(1, 1, 1);
      do_start();
      k = 0;
      while (!(in1_ready && got_data.size() == 1) && k < 20) begin tick(1); k++; end
      check("pre_rst_acc1", in1_ready, 1);
      check("pre_rst_ovf", ovf, 1);
      rst_n = 1'b0;
      #1;
      check("arst_readys", {in0_ready, in1_ready, in2_ready}, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_packet", out_packet, 0);
      check("arst_busy_done_ovf", {busy, done, ovf}, 0);
      q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(2);
      new_pass();
      push(11, 22, 33); push(0, 0, 1); push(100, 100, 100);
      do_start();
      wait_done(40);
      check("post_rst_idx0", got_idx[0], 0);
      check("post_rst_data0", got_data[0], 66);
      check("post_rst_data2", got_data[2], 255);
      check("post_rst_ovf", ovf, 1);
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_adder_sched.md
# psum_adder_sched

Clocked scheduler for the partial-sum adder stage. It takes the per-PE psum queues that the adder depacketizer fans out (PE0, PE1, PE2), and accumulates one psum from each queue in fixed order into a single output-row sum. It saturates the result to the data width and emits it as a network packet addressed to the output memory. It sequences NUM_OUT outputs per pass and signals completion to the top-level controller.

## Interface
- DWIDTH, 8, psum data width on each input queue and in the output packet data field
- PWIDTH, 47, output packet width; must be ≥ 46
- NUM_OUT, 9, outputs produced per pass (1..256)
- SRC_ADDR, 3'd4, value placed in packet source field [42:40]
- DST_ADDR, 3'd5, value placed in packet destination field [45:43]
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a pass; honoured only in IDLE
- in0_valid / in0_ready / in0_data  in / out / in  1 / 1 / DWIDTH  PE0 psum queue
- in1_valid / in1_ready / in1_data  in / out / in  1 / 1 / DWIDTH  PE1 psum queue
- in2_valid / in2_ready / in2_data  in / out / in  1 / 1 / DWIDTH  PE2 psum queue
- out_valid  out  1  output packet valid
- out_ready  in  1  downstream accepts the packet
- out_packet  out  PWIDTH  output packet
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last packet of a pass is accepted
- ovf  out  1  sticky flag; set when any output of the current pass saturated

## Operation
- Internal state: accumulator acc[DWIDTH+1:0] (unsigned), output index idx[7:0].
- Data is unsigned; the full sum of three inputs never wraps inside acc.
- FSM states: IDLE, ACC0, ACC1, ACC2, SEND.
- IDLE: all readys low. On start, clear acc, idx and ovf, then go to ACC0.
- ACCk (k = 0, 1, 2): ink_ready = 1 and every other ready = 0. On the ink_valid & ink_ready handshake, acc ← acc + ink_data and the FSM advances. ACC0 loads instead of adds (acc ← in0_data). ACC2 goes to SEND.
- Fixed order PE0 → PE1 → PE2. A queue offering data out of turn is stalled, never reordered.
- SEND: out_valid = 1. On out_ready:
  - if idx == NUM_OUT-1: go to IDLE and pulse done;
  - otherwise idx ← idx+1, acc ← 0, and go to ACC0.
- Saturation: data field = (acc > 2^DWIDTH-1) ? 2^DWIDTH-1 : acc[DWIDTH-1:0]. Saturation sets ovf, which stays set until the next accepted start or reset.
- out_packet layout:
  - [45:43] = DST_ADDR
  - [42:40] = SRC_ADDR
  - [39:32] = idx
  - [DWIDTH-1:0] = saturated data
  - all other bits 0
- start outside IDLE is ignored. It is neither queued nor able to restart the pass.

## Timing
- Reset (rst_n low, async): state = IDLE, acc = 0, idx = 0. Outputs: all in*_ready = 0, out_valid = 0, out_packet = 0, busy = 0, done = 0, ovf = 0.
- Reset mid-pass aborts immediately. Partially accumulated data is discarded and no done pulse is produced.
- Readys and out_valid are decoded from registered state only. There is no combinational path from any valid or out_ready to any ready or out_valid.
- start sampled high in IDLE → busy = 1 and in0_ready = 1 in the next cycle.
- Each handshake costs one cycle. The FSM advances on the same edge as the handshake.
- out_valid rises in the cycle after the in2 handshake.
- Minimum time per output: 4 cycles (3 accepts + 1 send). Minimum pass time: 4·NUM_OUT cycles after start.
- out_packet is registered and stable while out_valid = 1 and out_ready = 0.
- done is high for exactly one cycle: the cycle after the final out_ready handshake, coincident with busy = 0.
- A start coincident with done, or earlier, is ignored. Sampling resumes from the IDLE cycle onward.

## Test plan
- Reset, then NUM_OUT=3, start, all valids and out_ready held high. Inputs (10, 20, 30), (1, 2, 3), (0, 0, 0) → three packets with data 60, 6, 0 and idx 0, 1, 2; [45:43]=5; [42:40]=4; done pulses 12 cycles after start; ovf = 0.
- Saturation: inputs 200, 100, 50 (DWIDTH = 8) → data 255, ovf = 1. ovf stays set for the rest of the pass and clears on the next start.
- Out-of-order arrival: in2_valid high first, then in1, then in0 → in2 and in1 stall with ready low until their turn; the sum is correct; the handshakes occur in order 0, 1, 2.
- Backpressure: out_ready low for 5 cycles during SEND → out_valid and out_packet stay stable, all in*_ready stay low, and idx does not advance until acceptance.
- Start while busy and start with no pending data: a second start mid-pass has no effect, and the packet count stays NUM_OUT. Start with all valids low → the FSM holds in ACC0 with busy = 1.
- Async reset asserted in ACC1 mid-pass → all outputs return to reset values without a clock edge. A fresh start then produces a correct pass from idx 0.
